vending_machine: RTL and testbench

- Coin-credit vending controller driven by a single-column, 4-key active-low keypad (`row`).
- Decodes key presses into coin insertion, purchase and cancel actions, and keeps a decimal credit.
- Shows the credit on three 7-segment digits and exports the last decoded key code.
- Top-level user-interface block of the FPGA vending design.

---
 rtl/vending_machine.sv | 275 +++++++++++++++++++++++++++
 tb/tb_vending_machine.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vending_machine.sv
// vending_machine: coin-credit vending controller driven by a 4-key,
// active-low, single-column keypad.
//   key 1 adds COIN_A, key 2 adds COIN_B (both saturate at MAX_CREDIT),
//   key 3 buys for PRICE when credit allows, key 4 clears credit.
// Credit is shown on three 7-segment digits (D2 hundreds .. D0 units) and
// the last accepted key code is exported on key_value.
// Optional build macro VENDING_DEBOUNCE_EN: a key pattern (and the
// all-released pattern) must stay identical for DEBOUNCE_CYCLES
// synchronized samples before it is acted on.
module vending_machine #(
  parameter int COIN_A          = 5,
  parameter int COIN_B          = 10,
  parameter int PRICE           = 15,
  parameter int MAX_CREDIT      = 995,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [6:0] D0,
  output logic [6:0] D1,
  output logic [6:0] D2,
  output logic [3:0] key_value
);

  // ---------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------
  localparam logic [3:0]  NO_KEY     = 4'b1111;
  localparam logic [6:0]  SEG_ZERO   = 7'b0111111;
  localparam logic [10:0] COIN_A_W   = 11'(COIN_A);
  localparam logic [10:0] COIN_B_W   = 11'(COIN_B);
  localparam logic [10:0] PRICE_W    = 11'(PRICE);
  localparam logic [10:0] MAX_W      = 11'(MAX_CREDIT);
  localparam logic [9:0]  PRICE_C    = 10'(PRICE);
  localparam logic [9:0]  MAX_C      = 10'(MAX_CREDIT);

  // The stability counter exists in both builds; without debouncing it only
  // needs one sample, so every synchronized sample counts as stable.
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
`ifdef VENDING_DEBOUNCE_EN
  localparam int STABLE_NEED = DEBOUNCE_CYCLES;
`else
  localparam int STABLE_NEED = 1;
`endif
  localparam logic [CNT_W-1:0] NEED_C = CNT_W'(STABLE_NEED);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESSED = 1'b1
  } state_t;

  // ---------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------
  // Shift-add-3 conversion of a 10-bit value (< 1000) into three BCD digits.
  function automatic logic [11:0] bin_to_bcd(input logic [9:0] bin);
    logic [21:0] sh;
    sh = {12'd0, bin};
    for (int i = 0; i < 10; i++) begin
      for (int d = 0; d < 3; d++) begin
        if (sh[10 + 4*d +: 4] > 4'd4) begin
          sh[10 + 4*d +: 4] = sh[10 + 4*d +: 4] + 4'd3;
        end
      end
      sh = sh << 1;
    end
    return sh[21:10];
  endfunction

  // Segment pattern {g,f,e,d,c,b,a}, active-high.
  function automatic logic [6:0] seg_of(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  // ---------------------------------------------------------------------
  // Input synchronizer
  // ---------------------------------------------------------------------
  logic [3:0] sync1_reg;
  logic [3:0] sync2_reg;

  // Two-flop synchronizer; idles at the no-key pattern.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= NO_KEY;
      sync2_reg <= NO_KEY;
    end else begin
      sync1_reg <= row;
      sync2_reg <= sync1_reg;
    end
  end

  // ---------------------------------------------------------------------
  // Sample stability tracking
  // ---------------------------------------------------------------------
  logic [3:0]       last_sample_reg;
  logic [CNT_W-1:0] stable_cnt_reg;
  logic [CNT_W-1:0] stable_cnt_next;
  logic             sample_stable;

  // Count of consecutive identical synchronized samples, including the
  // current one, saturating at the number needed.
  always_comb begin
    stable_cnt_next = stable_cnt_reg;
    if (sync2_reg != last_sample_reg) begin
      stable_cnt_next = ONE_C;
    end else if (stable_cnt_reg < NEED_C) begin
      stable_cnt_next = stable_cnt_reg + ONE_C;
    end
  end

  assign sample_stable = (stable_cnt_next >= NEED_C);

  // Remember the previous sample and its run length.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_sample_reg <= NO_KEY;
      stable_cnt_reg  <= NEED_C;
    end else begin
      last_sample_reg <= sync2_reg;
      stable_cnt_reg  <= stable_cnt_next;
    end
  end

  // ---------------------------------------------------------------------
  // Key decode
  // ---------------------------------------------------------------------
  logic [3:0] key_code;
  logic       key_valid;
  logic       all_released;

  // Exactly one line low maps to a key; multi-key patterns decode to 0.
  always_comb begin
    key_code = 4'd0;
    case (sync2_reg)
      4'b1110: key_code = 4'd1;
      4'b1101: key_code = 4'd2;
      4'b1011: key_code = 4'd3;
      4'b0111: key_code = 4'd4;
      default: key_code = 4'd0;
    endcase
  end

  assign key_valid    = (key_code != 4'd0);
  assign all_released = (sync2_reg == NO_KEY);

  // ---------------------------------------------------------------------
  // Press FSM
  // ---------------------------------------------------------------------
  state_t state_reg;
  state_t state_next;
  logic   accept;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state: one action per press, re-arm only once fully released.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (key_valid && sample_stable) begin
          state_next = PRESSED;
        end
      end
      PRESSED: begin
        if (all_released && sample_stable) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM output: a key is accepted on the edge that leaves IDLE.
  always_comb begin
    accept = 1'b0;
    if (state_reg == IDLE && key_valid && sample_stable) begin
      accept = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Credit datapath
  // ---------------------------------------------------------------------
  logic [9:0]  credit_reg;
  logic [9:0]  credit_next;
  logic [3:0]  key_value_reg;
  logic [10:0] sum_a;
  logic [10:0] sum_b;

  assign sum_a = {1'b0, credit_reg} + COIN_A_W;
  assign sum_b = {1'b0, credit_reg} + COIN_B_W;

  // Credit update for the accepted key; additions saturate, purchase
  // only happens when enough credit is present.
  always_comb begin
    credit_next = credit_reg;
    if (accept) begin
      case (key_code)
        4'd1:    credit_next = (sum_a > MAX_W) ? MAX_C : sum_a[9:0];
        4'd2:    credit_next = (sum_b > MAX_W) ? MAX_C : sum_b[9:0];
        4'd3: begin
          if ({1'b0, credit_reg} >= PRICE_W) begin
            credit_next = credit_reg - PRICE_C;
          end
        end
        4'd4:    credit_next = 10'd0;
        default: credit_next = credit_reg;
      endcase
    end
  end

  // Credit and last-key registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      credit_reg    <= 10'd0;
      key_value_reg <= 4'd0;
    end else begin
      credit_reg <= credit_next;
      if (accept) begin
        key_value_reg <= key_code;
      end
    end
  end

  assign key_value = key_value_reg;

  // ---------------------------------------------------------------------
  // Display
  // ---------------------------------------------------------------------
  logic [11:0] credit_bcd;
  logic [6:0]  seg_reg [3];

  assign credit_bcd = bin_to_bcd(credit_reg);

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_digit
      // Registered segment driver for one decimal digit.
      always_ff @(posedge clk) begin
        if (reset) begin
          seg_reg[gi] <= SEG_ZERO;
        end else begin
          seg_reg[gi] <= seg_of(credit_bcd[4*gi +: 4]);
        end
      end
    end
  endgenerate

  assign D0 = seg_reg[0];
  assign D1 = seg_reg[1];
  assign D2 = seg_reg[2];

endmodule

// File: tb/tb_vending_machine.sv
// Self-checking bench for vending_machine (default build, no debouncing).
// A behavioural model keeps the expected credit and last key using plain
// arithmetic; displays are derived from decimal digits of that credit.
module tb_vending_machine;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] row = 4'b1111;
  logic [6:0] D0, D1, D2;
  logic [3:0] key_value;

  int n_cmp = 0;
  int n_bad = 0;

  int m_credit = 0;
  int m_key    = 0;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  vending_machine dut (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .D0        (D0),
    .D1        (D1),
    .D2        (D2),
    .key_value (key_value)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Key number for a pattern with exactly one line low, else 0.
  function automatic int key_of(logic [3:0] p);
    if ($countones(~p) != 1) return 0;
    for (int b = 0; b < 4; b++) if (!p[b]) return b + 1;
    return 0;
  endfunction

  function automatic int next_credit(int c, int k);
    case (k)
      1: return (c + 5 > 995) ? 995 : c + 5;
      2: return (c + 10 > 995) ? 995 : c + 10;
      3: return (c >= 15) ? c - 15 : c;
      4: return 0;
      default: return c;
    endcase
  endfunction

  function automatic logic [20:0] exp_disp(int c);
    return {seg_tab[c / 100], seg_tab[(c / 10) % 10], seg_tab[c % 10]};
  endfunction

  // Press a pattern for `hold` edges, release for `rel` edges; update model.
  task automatic press(logic [3:0] p, int hold, int rel);
    int k;
    k = key_of(p);
    row = p;
    repeat (hold) @(negedge clk);
    row = 4'b1111;
    repeat (rel) @(negedge clk);
    if (k != 0 && hold >= 3) begin
      m_credit = next_credit(m_credit, k);
      m_key    = k;
    end
    $display("press row=%b hold=%0d key=%0d -> credit=%0d key_value=%0d",
             p, hold, k, m_credit, m_key);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    row   = 4'b1111;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_credit = 0;
    m_key    = 0;
    n_cmp++;
    if ({D2, D1, D0} !== exp_disp(0)) begin
      n_bad++;
      $display("FAIL reset_disp got %h want %h", {D2, D1, D0}, exp_disp(0));
    end
    n_cmp++;
    if (key_value !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_key got %0d want 0", key_value);
    end
  endtask

  task automatic test_coin_a();
    row = 4'b1110;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (key_value !== 4'd0) begin
      n_bad++;
      $display("FAIL coin_a_early got %0d want 0", key_value);
    end
    @(negedge clk);
    n_cmp++;
    if (key_value !== 4'd1) begin
      n_bad++;
      $display("FAIL coin_a_latency got %0d want 1", key_value);
    end
    repeat (2) @(negedge clk);
    row = 4'b1111;
    repeat (4) @(negedge clk);
    m_credit = 5;
    m_key    = 1;
    $display("press row=1110 hold=5 key=1 -> credit=%0d key_value=%0d", m_credit, m_key);
    n_cmp++;
    if ({D2, D1, D0} !== {7'h3F, 7'h3F, 7'h6D}) begin
      n_bad++;
      $display("FAIL coin_a_disp got %h want %h", {D2, D1, D0}, {7'h3F, 7'h3F, 7'h6D});
    end
    press(4'b1110, 20, 4);
    n_cmp++;
    if ({D2, D1, D0} !== exp_disp(10)) begin
      n_bad++;
      $display("FAIL coin_a_long_hold got %h want %h", {D2, D1, D0}, exp_disp(10));
    end
  endtask

  task automatic test_purchase();
    press(4'b0111, 4, 4);
    press(4'b1101, 4, 4);
    press(4'b1110, 4, 4);
    n_cmp++;
    if ({D2, D1, D0} !== {7'h3F, 7'h06, 7'h6D}) begin
      n_bad++;
      $display("FAIL purchase_15 got %h want %h", {D2, D1, D0}, {7'h3F, 7'h06, 7'h6D});
    end
    press(4'b1011, 4, 4);
    n_cmp++;
    if ({D2, D1, D0} !== exp_disp(0) || key_value !== 4'd3) begin
      n_bad++;
      $display("FAIL purchase_buy got %h/%0d want %h/3", {D2, D1, D0}, key_value, exp_disp(0));
    end
  endtask

  task automatic test_insufficient();
    press(4'b1101, 4, 4);
    press(4'b1011, 4, 4);
    n_cmp++;
    if ({D2, D1, D0} !== exp_disp(10) || key_value !== 4'd3) begin
      n_bad++;
      $display("FAIL insufficient got %h/%0d want %h/3", {D2, D1, D0}, key_value, exp_disp(10));
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 102; i++) press(4'b1101, 3, 3);
    n_cmp++;
    if ({D2, D1, D0} !== {7'h6F, 7'h6F, 7'h6D} || m_credit != 995) begin
      n_bad++;
      $display("FAIL saturate got %h want %h", {D2, D1, D0}, {7'h6F, 7'h6F, 7'h6D});
    end
    press(4'b0111, 4, 4);
    n_cmp++;
    if ({D2, D1, D0} !== exp_disp(0) || key_value !== 4'd4) begin
      n_bad++;
      $display("FAIL cancel got %h/%0d want %h/4", {D2, D1, D0}, key_value, exp_disp(0));
    end
  endtask

  task automatic test_invalid();
    logic [3:0] pats [3] = '{4'b1100, 4'b0000, 4'b1001};
    press(4'b1110, 4, 4);
    for (int i = 0; i < 3; i++) begin
      press(pats[i], 10, 4);
      n_cmp++;
      if ({D2, D1, D0} !== exp_disp(m_credit) || key_value !== 4'(m_key)) begin
        n_bad++;
        $display("FAIL invalid_%b got %h/%0d want %h/%0d", pats[i], {D2, D1, D0},
                 key_value, exp_disp(m_credit), m_key);
      end
    end
  endtask

  task automatic test_glitch();
    int k;
    int alt_credit;
    for (int i = 0; i < 6; i++) begin
      k = 1 + int'($urandom_range(0, 2));
      alt_credit = next_credit(m_credit, k);
      #2 row = ~(4'b0001 << (k - 1));
      #1 row = 4'b1111;
      repeat (5) @(negedge clk);
      $display("glitch key=%0d -> credit=%0d key_value=%0d", k, m_credit, m_key);
      n_cmp++;
      if ({D2, D1, D0} === exp_disp(m_credit) && key_value === 4'(m_key)) begin
        // pulse not seen
      end else if ({D2, D1, D0} === exp_disp(alt_credit) && key_value === 4'(k)) begin
        m_credit = alt_credit;
        m_key    = k;
      end else begin
        n_bad++;
        $display("FAIL glitch_%0d got %h/%0d want %h/%0d or %h/%0d", i, {D2, D1, D0},
                 key_value, exp_disp(m_credit), m_key, exp_disp(alt_credit), k);
      end
    end
  endtask

  task automatic test_back_to_back();
    press(4'b0111, 3, 3);
    press(4'b1110, 3, 3);
    press(4'b1110, 3, 3);
    press(4'b1101, 3, 3);
    n_cmp++;
    if ({D2, D1, D0} !== exp_disp(20) || key_value !== 4'd2) begin
      n_bad++;
      $display("FAIL back_to_back got %h/%0d want %h/2", {D2, D1, D0}, key_value, exp_disp(20));
    end
  endtask

  task automatic test_reset_mid_press();
    row = 4'b1101;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    m_credit = 0;
    m_key    = 0;
    n_cmp++;
    if ({D2, D1, D0} !== exp_disp(0) || key_value !== 4'd0) begin
      n_bad++;
      $display("FAIL midreset_clear got %h/%0d want %h/0", {D2, D1, D0}, key_value, exp_disp(0));
    end
    reset = 1'b0;
    repeat (6) @(negedge clk);
    row = 4'b1111;
    repeat (4) @(negedge clk);
    m_credit = 10;
    m_key    = 2;
    $display("reset mid-press row=1101 -> credit=%0d key_value=%0d", m_credit, m_key);
    n_cmp++;
    if ({D2, D1, D0} !== exp_disp(10) || key_value !== 4'd2) begin
      n_bad++;
      $display("FAIL midreset_repress got %h/%0d want %h/2", {D2, D1, D0}, key_value, exp_disp(10));
    end
  endtask

  task automatic test_random();
    logic [3:0] p;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 5) == 0) p = 4'($urandom_range(0, 15));
      else p = ~(4'b0001 << $urandom_range(0, 3));
      if (p == 4'b1111) p = 4'b1110;
      press(p, int'($urandom_range(3, 8)), int'($urandom_range(3, 5)));
      n_cmp++;
      if ({D2, D1, D0} !== exp_disp(m_credit) || key_value !== 4'(m_key)) begin
        n_bad++;
        $display("FAIL random_%0d got %h/%0d want %h/%0d", i, {D2, D1, D0},
                 key_value, exp_disp(m_credit), m_key);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_coin_a();
    test_purchase();
    test_insufficient();
    test_saturation();
    test_invalid();
    test_glitch();
    test_back_to_back();
    test_reset_mid_press();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
